// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, with valid/ready on both sides.
// Byte i of the state, the key and every round key sits at bits [8i+7:8i].
package aes_dec_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128, which is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte (row r, column c) is byte 4c+r; row r moves right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*((c+r)%4)+r) +: 8] = s[8*(4*c+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < j; i++) rc = xtime(rc);
    return rc;
  endfunction

endpackage

module aes_key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]       key,
  output logic [128*(Nr+1)-1:0]  fullkeys
);
  import aes_dec_pkg::*;

  localparam int NW = 4*(Nr+1);

  // Word i holds key-schedule bytes 4i..4i+3 with byte 4i in bits [7:0].
  for (genvar i = 0; i < NW; i++) begin : g_w
    logic [31:0] wd;
    if (i < Nk) begin : g_key
      assign wd = key[32*i +: 32];
    end else if (i % Nk == 0) begin : g_rot
      assign wd = g_w[i-Nk].wd ^ sub_word({g_w[i-1].wd[7:0], g_w[i-1].wd[31:8]})
                ^ {24'h000000, rcon(i / Nk)};
    end else if (Nk > 6 && i % Nk == 4) begin : g_sub
      assign wd = g_w[i-Nk].wd ^ sub_word(g_w[i-1].wd);
    end else begin : g_xor
      assign wd = g_w[i-Nk].wd ^ g_w[i-1].wd;
    end
  end

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign fullkeys[128*(Nr+1)-1-128*r -: 128] =
      {g_w[4*r+3].wd, g_w[4*r+2].wd, g_w[4*r+1].wd, g_w[4*r].wd};
  end

endmodule

module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   cipherText,
  input  logic [N-1:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   plainText,
  output logic           busy
);
  import aes_dec_pkg::*;

  localparam int RW = $clog2(Nr+1);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/plainText stay stable from the rise of out_valid until that transfer.
  fsm_e            fsm_q, fsm_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [127:0]    state_q, state_d;
  logic [N-1:0]    key_q, key_d;

  logic [128*(Nr+1)-1:0] fullkeys;
  logic [127:0]          rk [Nr+1];
  logic [127:0]          inv_sr_sb;

  aes_key_expansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
    .key      (key_q),
    .fullkeys (fullkeys)
  );

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk[r] = fullkeys[128*(Nr+1)-1-128*r -: 128];
  end

  assign inv_sr_sb = inv_sub_bytes(inv_shift_rows(state_q));

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    key_d   = key_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = cipherText;
          key_d   = key;
          fsm_d   = INIT;
        end
      end
      INIT: begin
        state_d = state_q ^ rk[Nr];
        rnd_d   = RW'(Nr - 1);
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = inv_mix_columns(inv_sr_sb ^ rk[rnd_q]);
        rnd_d   = rnd_q - 1'b1;
        if (rnd_q == RW'(1)) fsm_d = FINAL;
      end
      FINAL: begin
        state_d = inv_sr_sb ^ rk[0];
        fsm_d   = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign plainText = state_q;

endmodule
